// File: rtl/ibex_ibus_arbiter.sv
// ibex_ibus_arbiter
//
// Shares the single instruction-side bus between two requesters. Port 0 is
// the fetch path (prefetch buffer / icache). Port 1 is an auxiliary requester.
// A request is selected in IDLE and presented on the bus in the same cycle.
// If the bus does not grant it, the owner FSM moves to HOLD and keeps that
// owner's request and address stable until the grant arrives.
// Each granted transaction pushes its owner ID into an in-order FIFO. Each
// instr_rvalid_i pops that FIFO so the response goes back to the requester
// that issued it.
//
// Handshake: a requester raises reqN_i with addrN_i stable and keeps both
// until gntN_o is seen high in a cycle. That cycle is the acceptance cycle.
// The bus side follows the same rule: instr_req_o/instr_addr_o are stable
// until instr_gnt_i. A response is a single-cycle rvalidN_o pulse with
// rdata_o/errN_o. There is no back-pressure on responses.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req0_i/req1_i             requests from port 0 / port 1
//   addr0_i/addr1_i           word addresses; bits [1:0] are driven as 0
//   gnt0_o/gnt1_o             grant back to each requester
//   rvalid0_o/rvalid1_o       response valid, routed by owner FIFO
//   err0_o/err1_o             bus error qualified with the response
//   pmp_err0_o/pmp_err1_o     PMP rejection, forwarded to current owner
//   rdata_o                   shared response data
//   instr_req_o/instr_addr_o  bus request and address
//   instr_gnt_i               bus grant
//   instr_rvalid_i            bus response valid
//   instr_rdata_i             bus response data
//   instr_err_i               bus response error
//   instr_pmp_err_i           PMP rejection of the current request
//   busy_o                    request pending or transactions outstanding
//   protocol_err_o            sticky: response arrived with nothing outstanding

module ibex_ibus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FetchPriority  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        pmp_err0_o,
  output logic        pmp_err1_o,
  output logic [31:0] rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_pmp_err_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // The owner FSM state is kept as one struct so it can be probed as a unit.
  typedef struct packed {
    state_e state;
    logic   owner;
  } fsm_t;

  fsm_t                      fsm_q;
  logic                      rr_q;      // port preferred on the next contention
  logic [CntW-1:0]           cnt_q;
  logic [MaxOutstanding-1:0] fifo_q;    // owner IDs, head at bit 0
  logic                      protocol_err_q;

  logic                      full;
  logic                      empty;
  logic                      owner;
  logic                      req_raw;
  logic                      bus_req;
  logic                      push;
  logic                      pop;
  logic                      head;
  logic [31:0]               addr_sel;
  logic [CntW-1:0]           wr_idx;
  logic [CntW-1:0]           cnt_d;
  logic [MaxOutstanding-1:0] fifo_d;

  // The low address bits are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{addr0_i[1:0], addr1_i[1:0]};

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);

  // Winner selection. In HOLD the held owner is kept, and the other port is
  // ignored whatever the priority setting.
  always_comb begin
    owner   = 1'b0;
    req_raw = 1'b0;
    if (fsm_q.state == StHold) begin
      owner   = fsm_q.owner;
      req_raw = fsm_q.owner ? req1_i : req0_i;
    end else begin
      if (req0_i && req1_i) begin
        owner = FetchPriority ? 1'b0 : rr_q;
      end else begin
        owner = req1_i;
      end
      req_raw = req0_i | req1_i;
    end
  end

  // Fullness uses the registered count. A slot freed by a pop is therefore
  // usable only from the next cycle.
  assign bus_req = rst_ni & req_raw & ~full;
  assign push    = bus_req & instr_gnt_i;
  assign pop     = instr_rvalid_i & ~empty;
  assign head    = fifo_q[0];

  assign addr_sel     = owner ? addr1_i : addr0_i;
  assign instr_req_o  = bus_req;
  assign instr_addr_o = bus_req ? {addr_sel[31:2], 2'b00} : 32'h0;

  assign gnt0_o     = push & ~owner;
  assign gnt1_o     = push & owner;
  assign pmp_err0_o = bus_req & instr_pmp_err_i & ~owner;
  assign pmp_err1_o = bus_req & instr_pmp_err_i & owner;

  assign rvalid0_o = pop & ~head;
  assign rvalid1_o = pop & head;
  assign err0_o    = rvalid0_o & instr_err_i;
  assign err1_o    = rvalid1_o & instr_err_i;
  assign rdata_o   = pop ? instr_rdata_i : 32'h0;

  assign busy_o         = bus_req | ~empty;
  assign protocol_err_o = protocol_err_q;

  // Owner FIFO as a shift register: a pop shifts toward bit 0, and a push
  // writes just above the last valid entry after any pop.
  always_comb begin
    fifo_d = pop ? (fifo_q >> 1) : fifo_q;
    wr_idx = pop ? (cnt_q - CntW'(1)) : cnt_q;
    if (push) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (CntW'(i) == wr_idx) fifo_d[i] = owner;
      end
    end
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q          <= '{state: StIdle, owner: 1'b0};
      rr_q           <= 1'b0;
      cnt_q          <= '0;
      fifo_q         <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      case (fsm_q.state)
        StIdle: begin
          if (bus_req && !instr_gnt_i) fsm_q <= '{state: StHold, owner: owner};
        end
        StHold: begin
          // Leave on grant, or when the owner withdraws. A withdrawn request
          // pushes nothing.
          if (!bus_req || instr_gnt_i) fsm_q <= '{state: StIdle, owner: 1'b0};
        end
        default: fsm_q <= '{state: StIdle, owner: 1'b0};
      endcase
      if (push) rr_q <= ~owner;
      cnt_q  <= cnt_d;
      fifo_q <= fifo_d;
      if (instr_rvalid_i && empty) protocol_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
// Testbench for ibex_ibus_arbiter.
// A reference model holds the outstanding owners in a queue and computes every
// output from the current inputs each cycle. Directed sequences add fixed
// literal expectations. A randomized phase follows them.

module tb_ibex_ibus_arbiter;

  localparam int MAX = 2;
  localparam bit FP  = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rv0, rv1, err0, err1, perr0, perr1;
  logic [31:0] rdata;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt, bus_rvalid, bus_err, bus_pmp;
  logic [31:0] bus_rdata;
  logic        busy, proto_err;

  ibex_ibus_arbiter #(.MaxOutstanding(MAX), .FetchPriority(FP)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req0_i         (req0),
    .req1_i         (req1),
    .addr0_i        (addr0),
    .addr1_i        (addr1),
    .gnt0_o         (gnt0),
    .gnt1_o         (gnt1),
    .rvalid0_o      (rv0),
    .rvalid1_o      (rv1),
    .err0_o         (err0),
    .err1_o         (err1),
    .pmp_err0_o     (perr0),
    .pmp_err1_o     (perr1),
    .rdata_o        (rdata),
    .instr_req_o    (bus_req),
    .instr_addr_o   (bus_addr),
    .instr_gnt_i    (bus_gnt),
    .instr_rvalid_i (bus_rvalid),
    .instr_rdata_i  (bus_rdata),
    .instr_err_i    (bus_err),
    .instr_pmp_err_i(bus_pmp),
    .busy_o         (busy),
    .protocol_err_o (proto_err)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];     // owners of outstanding transactions, oldest first
  bit         m_hold_v, m_hold_w, m_rr, m_perr;

  logic        e_req, e_owner, e_gnt0, e_gnt1, e_rv0, e_rv1, e_err0, e_err1;
  logic        e_perr0, e_perr1, e_busy, e_proto;
  logic [31:0] e_addr, e_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_hold_v = 0; m_hold_w = 0; m_rr = 0; m_perr = 0;
  endtask

  task automatic model_outputs();
    logic [31:0] a;
    logic        hd;
    e_req = 0; e_owner = 0; e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0;
    e_err0 = 0; e_err1 = 0; e_perr0 = 0; e_perr1 = 0; e_busy = 0;
    e_addr = 0; e_rdata = 0; e_proto = 0;
    if (!rst_ni) begin
      model_clear();
      return;
    end
    if (m_hold_v) begin
      e_owner = m_hold_w;
      e_req   = (m_hold_w ? req1 : req0) && (exp_q.size() < MAX);
    end else if ((exp_q.size() < MAX) && (req0 || req1)) begin
      e_req   = 1;
      e_owner = (req0 && req1) ? (FP ? 1'b0 : m_rr) : req1;
    end
    if (e_req) begin
      a       = e_owner ? addr1 : addr0;
      e_addr  = {a[31:2], 2'b00};
      e_gnt0  = bus_gnt && !e_owner;
      e_gnt1  = bus_gnt && e_owner;
      e_perr0 = bus_pmp && !e_owner;
      e_perr1 = bus_pmp && e_owner;
    end
    if (bus_rvalid && exp_q.size() > 0) begin
      hd      = exp_q[0];
      e_rv0   = !hd;
      e_rv1   = hd;
      e_err0  = !hd && bus_err;
      e_err1  = hd && bus_err;
      e_rdata = bus_rdata;
    end
    e_busy  = e_req || (exp_q.size() > 0);
    e_proto = m_perr;
  endtask

  task automatic model_update();
    if (!rst_ni) begin
      model_clear();
      return;
    end
    if (bus_rvalid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else m_perr = 1;
    end
    if (e_req && bus_gnt) begin
      exp_q.push_back(e_owner);
      m_rr     = ~e_owner;
      m_hold_v = 0;
    end else if (e_req) begin
      m_hold_v = 1;
      m_hold_w = e_owner;
    end else begin
      m_hold_v = 0;
    end
  endtask

  // Compare all outputs against the model. This runs just after inputs change
  // at the falling edge.
  task automatic settle();
    #1;
    model_outputs();
    chk("instr_req_o",    bus_req,   e_req);
    chk("instr_addr_o",   bus_addr,  e_addr);
    chk("gnt0_o",         gnt0,      e_gnt0);
    chk("gnt1_o",         gnt1,      e_gnt1);
    chk("rvalid0_o",      rv0,       e_rv0);
    chk("rvalid1_o",      rv1,       e_rv1);
    chk("err0_o",         err0,      e_err0);
    chk("err1_o",         err1,      e_err1);
    chk("pmp_err0_o",     perr0,     e_perr0);
    chk("pmp_err1_o",     perr1,     e_perr1);
    chk("rdata_o",        rdata,     e_rdata);
    chk("busy_o",         busy,      e_busy);
    chk("protocol_err_o", proto_err, e_proto);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_pmp = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    settle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
    advance();
    advance();
    drive_idle();
    rst_ni = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    model_clear();
    @(negedge clk);

    // Single fetch, response two cycles after the grant.
    do_reset();
    req0 = 1; addr0 = 32'h0000_1004; bus_gnt = 1;
    settle();
    chk("sf_gnt0", gnt0, 1'b1);
    chk("sf_addr", bus_addr, 32'h0000_1004);
    advance();
    drive_idle();
    settle();
    chk("sf_busy_mid", busy, 1'b1);
    advance();
    bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    chk("sf_rv0", rv0, 1'b1);
    chk("sf_rdata", rdata, 32'hDEAD_BEEF);
    chk("sf_rv1", rv1, 1'b0);
    advance();
    drive_idle();
    settle();
    chk("sf_busy_end", busy, 1'b0);
    advance();

    // Round-robin under constant contention with the bus always granting.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req0 = 1; req1 = 1; bus_gnt = 1;
      addr0 = $urandom; addr1 = $urandom | 32'h3;
      bus_rvalid = (k > 0); bus_rdata = $urandom;
      settle();
      chk("rr_gnt0", gnt0, (k % 2) == 0);
      chk("rr_gnt1", gnt1, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_rv0", rv0, ((k - 1) % 2) == 0);
        chk("rr_rv1", rv1, ((k - 1) % 2) == 1);
      end
      advance();
    end
    drive_idle(); bus_rvalid = 1;
    settle(); advance();

    // Hold: port 1 wins alone, then port 0 joins while the bus stalls.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req1 = 1; addr1 = 32'hABCD_0013;
      req0 = (k > 0); addr0 = 32'h0000_2000;
      bus_gnt = (k == 3);
      settle();
      chk("hold_addr", bus_addr, 32'hABCD_0010);
      chk("hold_gnt1", gnt1, k == 3);
      chk("hold_gnt0", gnt0, 1'b0);
      advance();
    end
    req1 = 0; req0 = 1; bus_gnt = 1;
    settle();
    chk("hold_next_gnt0", gnt0, 1'b1);
    chk("hold_next_addr", bus_addr, 32'h0000_2000);
    advance();
    drive_idle(); bus_rvalid = 1;
    settle(); advance();
    settle(); advance();

    // Full FIFO: no bus request while full, and the next issue comes one
    // cycle after the pop.
    do_reset();
    req0 = 1; addr0 = 32'h0000_0100; bus_gnt = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("full_gnt", gnt0, 1'b1);
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("full_noreq", bus_req, 1'b0);
      chk("full_busy", busy, 1'b1);
      advance();
    end
    bus_rvalid = 1;
    settle();
    chk("full_pop_noreq", bus_req, 1'b0);
    chk("full_pop_rv0", rv0, 1'b1);
    advance();
    bus_rvalid = 0;
    settle();
    chk("full_reissue", bus_req, 1'b1);
    chk("full_reissue_gnt", gnt0, 1'b1);
    advance();
    drive_idle(); bus_rvalid = 1;
    settle(); advance();
    settle(); advance();

    // Bus error and PMP error on port 1.
    do_reset();
    req1 = 1; addr1 = 32'h8000_0000; bus_gnt = 1; bus_pmp = 1;
    settle();
    chk("pmp1", perr1, 1'b1);
    chk("pmp0", perr0, 1'b0);
    chk("pmp_gnt1", gnt1, 1'b1);
    advance();
    drive_idle(); bus_rvalid = 1; bus_err = 1; bus_rdata = 32'h1234_5678;
    settle();
    chk("err1", err1, 1'b1);
    chk("err0", err0, 1'b0);
    chk("err_rv1", rv1, 1'b1);
    advance();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      addr0 = $urandom; addr1 = $urandom;
      bus_gnt = $urandom_range(0, 1);
      bus_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      bus_err = ($urandom_range(0, 4) == 0);
      bus_pmp = ($urandom_range(0, 9) == 0);
      bus_rdata = $urandom;
      settle();
      advance();
    end

    // Response with nothing outstanding sets a sticky error.
    do_reset();
    bus_rvalid = 1; bus_rdata = 32'hCAFE_0000;
    settle();
    chk("perr_same_cycle", proto_err, 1'b0);
    chk("perr_rv0", rv0, 1'b0);
    chk("perr_rv1", rv1, 1'b0);
    advance();
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("perr_sticky", proto_err, 1'b1);
      advance();
    end

    // Reset with two transactions outstanding.
    do_reset();
    req0 = 1; addr0 = 32'h0000_0040; bus_gnt = 1;
    settle(); advance();
    settle(); advance();
    drive_idle();
    settle();
    chk("rmid_busy_before", busy, 1'b1);
    advance();
    do_reset();
    settle();
    chk("rmid_busy_after", busy, 1'b0);
    advance();
    bus_rvalid = 1;
    settle();
    chk("rmid_rv0", rv0, 1'b0);
    advance();
    drive_idle();
    settle();
    chk("rmid_proto", proto_err, 1'b1);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
